// File: rtl/unary_pkg.sv
// Shared types for the unary operand serializer: FSM state encoding and the
// default operand width.
package unary_pkg;

  localparam int DEFAULT_INPUT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/unary_shift_reg.sv
// Parallel-load, LSB-first shift register; one instance per operand.
// The current serial bit is always available on lsb.
module unary_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             shift,
  output logic             lsb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (shift) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/unary_operand_serializer.sv
// Streams operand pairs LSB-first to a unary multiplier as CLEAR/SHIFT/DRAIN
// frames, with a one-entry pending buffer so a second pair can queue up.
module unary_operand_serializer
  import unary_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEFAULT_INPUT_WIDTH,
  parameter int COUNT_WIDTH  = $clog2(INPUT_WIDTH + 1),
  parameter int DRAIN_CYCLES = INPUT_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  // Handshake: a pair transfers on a rising edge where in_valid && in_ready.
  // in_valid may be held; the pair is sampled only on the transferring edge.
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] a_word,
  input  logic [INPUT_WIDTH-1:0] b_word,
  output logic                   clr_n,
  output logic                   a,
  output logic                   b,
  output logic [1:0]             ready,
  output logic                   busy,
  output logic                   done,
  output state_t                 dbg_state
);

  localparam logic [COUNT_WIDTH-1:0] BIT_LAST   = COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] DRAIN_LAST = COUNT_WIDTH'(DRAIN_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] bit_cnt, bit_d;
  logic [COUNT_WIDTH-1:0] drain_cnt, drain_d;
  logic                   pending_full;
  logic [INPUT_WIDTH-1:0] pend_a, pend_b;
  logic                   accept, drain_exit;
  logic                   load, load_from_pend, pend_load, pend_clear;
  logic                   shift_en, a_lsb, b_lsb;
  logic [INPUT_WIDTH-1:0] load_a, load_b;

  assign in_ready   = !pending_full;
  assign accept     = in_valid && in_ready;
  assign drain_exit = (state_q == DRAIN) && (drain_cnt == DRAIN_LAST);
  assign dbg_state  = state_q;

  always_comb begin
    state_d        = state_q;
    bit_d          = bit_cnt;
    drain_d        = drain_cnt;
    load           = 1'b0;
    load_from_pend = 1'b0;
    pend_clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CLEAR;
          load    = 1'b1;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
        bit_d   = '0;
      end
      SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          bit_d = bit_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          if (pending_full) begin
            state_d        = CLEAR;
            load           = 1'b1;
            load_from_pend = 1'b1;
            pend_clear     = 1'b1;
          end else if (accept) begin
            // Pair arriving on the exit edge goes straight to active.
            state_d = CLEAR;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          drain_d = drain_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pend_load = accept && (state_q != IDLE) && !drain_exit;
  assign load_a    = load_from_pend ? pend_a : a_word;
  assign load_b    = load_from_pend ? pend_b : b_word;
  // Shifting on the edge into SHIFT lets the registered output take bit 0
  // while the register advances to bit 1.
  assign shift_en  = (state_d == SHIFT);

  unary_shift_reg #(.WIDTH(INPUT_WIDTH)) u_shift_a (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .data  (load_a),
    .shift (shift_en),
    .lsb   (a_lsb)
  );

  unary_shift_reg #(.WIDTH(INPUT_WIDTH)) u_shift_b (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .data  (load_b),
    .shift (shift_en),
    .lsb   (b_lsb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt      <= '0;
      drain_cnt    <= '0;
      pending_full <= 1'b0;
      pend_a       <= '0;
      pend_b       <= '0;
      clr_n        <= 1'b1;
      a            <= 1'b0;
      b            <= 1'b0;
      ready        <= 2'b00;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt   <= bit_d;
      drain_cnt <= drain_d;
      if (pend_load) begin
        pend_a       <= a_word;
        pend_b       <= b_word;
        pending_full <= 1'b1;
      end else if (pend_clear) begin
        pending_full <= 1'b0;
      end
      // Outputs are decoded from the next state so they line up with state_q.
      clr_n <= (state_d != CLEAR);
      a     <= (state_d == SHIFT) && a_lsb;
      b     <= (state_d == SHIFT) && b_lsb;
      ready <= (state_d == SHIFT) ? 2'b11 : 2'b00;
      busy  <= (state_d != IDLE);
      done  <= (state_d == DRAIN) && (drain_d == DRAIN_LAST);
    end
  end

endmodule

// File: tb/tb_unary_operand_serializer.sv
// Self-checking bench for unary_operand_serializer: scenario tasks with inline
// checks plus a stream monitor popping expected pairs from a queue.
module tb_unary_operand_serializer;
  import unary_pkg::*;

  localparam int W           = 8;
  localparam int DC          = W + 1;
  localparam int STALL_LIMIT = 100;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a_word = '0;
  logic [W-1:0] b_word = '0;
  logic         in_ready, clr_n, a, b, busy, done;
  logic [1:0]   ready;
  state_t       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] stim_q[$];

  logic [W-1:0] mon_a, mon_b;
  int           mon_cnt = 0;

  unary_operand_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .clr_n     (clr_n),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Stream monitor: rebuilds each LSB-first word and compares with the queue.
  always @(negedge clk) begin
    logic [2*W-1:0] exp_v;
    if (!reset) begin
      mon_cnt = 0;
    end else if (ready == 2'b11) begin
      mon_a = {a, mon_a[W-1:1]};
      mon_b = {b, mon_b[W-1:1]};
      mon_cnt++;
      if (mon_cnt == W) begin
        mon_cnt = 0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_unexpected: got a=%h b=%h, required no stream", mon_a, mon_b);
        end else begin
          exp_v = exp_q.pop_front();
          if ({mon_a, mon_b} !== exp_v) begin
            n_fail++;
            $display("FAIL stream_data: got a=%h b=%h, required a=%h b=%h",
                     mon_a, mon_b, exp_v[2*W-1:W], exp_v[W-1:0]);
          end
        end
      end
    end
  end

  // Offers every pair in stim_q; called and returns at a falling edge.
  task automatic run_stim(input int gap_max, output int stalls);
    logic [2*W-1:0] p;
    int t;
    stalls = 0;
    while (stim_q.size() > 0) begin
      p = stim_q.pop_front();
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
      in_valid = 1'b1;
      a_word   = p[2*W-1:W];
      b_word   = p[W-1:0];
      t = 0;
      while (!in_ready && t < STALL_LIMIT) begin
        @(negedge clk);
        stalls++;
        t++;
      end
      n_checks++;
      if (!in_ready) begin
        n_fail++;
        $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
      end else begin
        exp_q.push_back(p);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    a_word   = W'($urandom);
    b_word   = W'($urandom);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, clr_n, a, b, ready, busy, done} !== 8'b1100_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 11000000",
               {in_ready, clr_n, a, b, ready, busy, done});
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, IDLE);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, busy, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b, required 100", {in_ready, busy, done});
    end
  endtask

  // Cycle-by-cycle frame check for a single pair accepted from IDLE.
  task automatic test_single_frame(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [6:0] exp_v, got_v;
    in_valid = 1'b1;
    a_word   = av;
    b_word   = bv;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_in_ready: got %b, required 1", in_ready);
    end
    exp_q.push_back({av, bv});
    for (int k = 1; k <= W + DC + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        a_word   = ~av;
        b_word   = ~bv;
      end
      if (k == 1)
        exp_v = 7'b0_0_0_00_1_0;
      else if (k <= W + 1)
        exp_v = {1'b1, av[k-2], bv[k-2], 2'b11, 1'b1, 1'b0};
      else if (k <= W + 1 + DC)
        exp_v = {1'b1, 1'b0, 1'b0, 2'b00, 1'b1, (k == W + 1 + DC)};
      else
        exp_v = 7'b1_0_0_00_0_0;
      got_v = {clr_n, a, b, ready, busy, done};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL frame_cycle_%0d: {clr_n,a,b,ready,busy,done} got %b, required %b",
                 k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit seen_done;
    @(negedge clk);
    in_valid = 1'b1;
    a_word   = 8'hFF;
    b_word   = 8'h01;
    exp_q.push_back({8'hFF, 8'h01});
    @(negedge clk);
    a_word = 8'h00;
    b_word = 8'h80;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_pending_ready: got %b, required 1", in_ready);
    end else begin
      exp_q.push_back({8'h00, 8'h80});
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_in_ready_drop: got %b, required 0", in_ready);
    end
    seen_done = 1'b0;
    for (int t = 0; t < 40 && !seen_done; t++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    n_checks++;
    if (!seen_done) begin
      n_fail++;
      $display("FAIL b2b_first_done: got no done, required done within 40 cycles");
    end
    @(negedge clk);
    n_checks++;
    if ({clr_n, busy, in_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b_no_idle_gap: {clr_n,busy,in_ready} got %b, required 011",
               {clr_n, busy, in_ready});
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_pending_hold;
    int stalls;
    bit ok;
    stim_q.push_back({8'h5A, 8'hC3});
    stim_q.push_back({8'h81, 8'h7E});
    stim_q.push_back({8'h12, 8'hED});
    run_stim(0, stalls);
    n_checks++;
    if (stalls != W + DC) begin
      n_fail++;
      $display("FAIL hold_stall_cycles: got %0d, required %0d", stalls, W + DC);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hold_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int stalls;
    int shifts;
    bit ok;
    stim_q.push_back({8'h99, 8'h66});
    stim_q.push_back({8'hE7, 8'h18});
    run_stim(0, stalls);
    shifts = (ready == 2'b11) ? 1 : 0;
    for (int t = 0; t < 40 && shifts < 4; t++) begin
      @(negedge clk);
      if (ready == 2'b11) shifts++;
    end
    n_checks++;
    if (shifts != 4) begin
      n_fail++;
      $display("FAIL midrst_shift_seen: got %0d shift cycles, required 4", shifts);
    end
    reset = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if ({in_ready, clr_n, a, b, ready, busy, done} !== 8'b1100_0000) begin
      n_fail++;
      $display("FAIL midrst_async: got %b, required 11000000",
               {in_ready, clr_n, a, b, ready, busy, done});
    end
    @(negedge clk);
    n_checks++;
    if ({in_ready, clr_n, a, b, ready, busy, done} !== 8'b1100_0000 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL midrst_next_cycle: got %b state %0d, required 11000000 state 0",
               {in_ready, clr_n, a, b, ready, busy, done}, dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    stim_q.push_back({8'h0F, 8'hF0});
    run_stim(0, stalls);
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_restream: busy=%b pending_expected=%0d, required 0 and 0",
               busy, exp_q.size());
    end
  endtask

  task automatic test_random;
    int stalls;
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 48; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i == 0) begin ra = '0; rb = '1; end
      if (i == 1) begin ra = '1; rb = '1; end
      if (i == 2) begin ra = '0; rb = '0; end
      stim_q.push_back({ra, rb});
    end
    run_stim(0, stalls);
    for (int i = 0; i < 24; i++) stim_q.push_back({W'($urandom), W'($urandom)});
    run_stim(W + DC + 4, stalls);
  endtask

  initial begin
    bit ok;
    test_reset();
    test_single_frame(8'hA5, 8'h3C);
    test_single_frame(8'h01, 8'h80);
    test_back_to_back();
    test_pending_hold();
    test_reset_mid();
    test_random();
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: busy=%b pending_expected=%0d, required 0 and 0",
               busy, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
